// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: XLEN, reset PC, alignment mask,
// fetch FSM state and the {pc, instr} queue entry.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] & INSTR_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic circular-buffer FIFO with push, pop and flush; head data reads as
// zero while empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, captures {pc, instr} pairs into a
// small queue for decode, and handles redirects and fetch faults.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] IMEM_BYTES = 32'd4096,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fault,
    output logic [31:0] fault_addr
);

    fetch_state_t state;
    logic [31:0]  pc;
    fetch_entry_t wentry;
    fetch_entry_t head;
    logic         q_full;
    logic         q_empty;
    logic [$clog2(FIFO_DEPTH):0] q_count;
    logic         push;
    logic         pop;
    logic         flush;
    logic         pc_in_range;
    logic         target_ok;

    assign pc_in_range = (pc < IMEM_BYTES);
    assign target_ok   = is_aligned(redirect_target) && (redirect_target < IMEM_BYTES);
    assign pop         = if_valid & if_ready;

    // Redirect outranks both push and pop: a same-cycle pop is squashed by the flush.
    always_comb begin
        push  = 1'b0;
        flush = 1'b0;
        if (state == RUN) begin
            if (redirect_valid) flush = 1'b1;
            else                push  = pc_in_range & (!q_full | pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (state == RUN) begin
            if (redirect_valid) begin
                if (target_ok) begin
                    pc <= redirect_target;
                end else begin
                    state      <= FAULT;
                    fault      <= 1'b1;
                    fault_addr <= redirect_target;
                end
            end else if (!pc_in_range) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_addr <= pc;
            end else if (push) begin
                pc <= pc + 32'd4;
            end
        end
    end

    assign wentry = '{pc: pc, instr: imem_rdata};

    fetch_queue #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wentry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign imem_addr = pc;
    assign if_valid  = (q_count != '0);
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;

    a_empty_consistent: assert property (
        @(posedge clk) disable iff (!reset) q_empty == (q_count == '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (4 KiB and 16-byte memories) share
// stimulus and are checked every cycle against a list-based model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] LIM [2] = '{32'd4096, 32'd16};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        if_ready = 1'b0;

    logic [31:0] imem_addr  [2];
    logic [31:0] imem_rdata [2];
    logic [31:0] if_pc      [2];
    logic [31:0] if_instr   [2];
    logic [31:0] fault_addr [2];
    logic        if_valid   [2];
    logic        fault      [2];

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    logic [31:0] m_pc  [2];
    logic [31:0] m_fa  [2];
    bit          m_fault [2];
    int          m_n   [2];
    logic [31:0] m_qpc [2][DEPTH];
    logic [31:0] m_qin [2][DEPTH];

    logic [31:0] del0 [$];
    logic [31:0] del1 [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return a ^ 32'hDEAD_0000 ^ {a[7:0], 24'h0};
    endfunction

    assign imem_rdata[0] = mem_word(imem_addr[0]);
    assign imem_rdata[1] = mem_word(imem_addr[1]);

    fetch_unit u_dut0 (
        .clk(clk), .reset(reset), .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid[0]), .if_ready(if_ready), .if_pc(if_pc[0]), .if_instr(if_instr[0]),
        .fault(fault[0]), .fault_addr(fault_addr[0])
    );

    fetch_unit #(.IMEM_BYTES(32'd16)) u_dut1 (
        .clk(clk), .reset(reset), .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid[1]), .if_ready(if_ready), .if_pc(if_pc[1]), .if_instr(if_instr[1]),
        .fault(fault[1]), .fault_addr(fault_addr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_pc[i] = 32'h0;
        m_fa[i] = 32'h0;
        m_fault[i] = 1'b0;
        m_n[i] = 0;
    endtask

    // One clock of the fetch rules: redirect flushes everything, else drop the
    // head on a pop and append the current PC if room remains.
    task automatic model_step(input int i);
        bit pop;
        pop = (m_n[i] > 0) && if_ready;
        if (!m_fault[i] && redirect_valid) begin
            m_n[i] = 0;
            if (redirect_target[1:0] == 2'b00 && redirect_target < LIM[i]) begin
                m_pc[i] = redirect_target;
            end else begin
                m_fault[i] = 1'b1;
                m_fa[i] = redirect_target;
            end
        end else begin
            if (pop) begin
                for (int k = 1; k < DEPTH; k++) begin
                    m_qpc[i][k-1] = m_qpc[i][k];
                    m_qin[i][k-1] = m_qin[i][k];
                end
                m_n[i]--;
            end
            if (!m_fault[i]) begin
                if (m_pc[i] >= LIM[i]) begin
                    m_fault[i] = 1'b1;
                    m_fa[i] = m_pc[i];
                end else if (m_n[i] < DEPTH) begin
                    m_qpc[i][m_n[i]] = m_pc[i];
                    m_qin[i][m_n[i]] = mem_word(m_pc[i]);
                    m_n[i]++;
                    m_pc[i] = m_pc[i] + 32'd4;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) model_reset(i);
            else        model_step(i);
        end
    end

    always @(negedge clk) begin
        if (en) begin
            for (int i = 0; i < 2; i++) begin
                if (!reset) model_reset(i);
                chk($sformatf("imem_addr%0d", i), imem_addr[i], m_pc[i]);
                chk($sformatf("if_valid%0d", i), {31'd0, if_valid[i]}, {31'd0, m_n[i] > 0});
                chk($sformatf("if_pc%0d", i), if_pc[i], (m_n[i] > 0) ? m_qpc[i][0] : 32'h0);
                chk($sformatf("if_instr%0d", i), if_instr[i], (m_n[i] > 0) ? m_qin[i][0] : 32'h0);
                chk($sformatf("fault%0d", i), {31'd0, fault[i]}, {31'd0, m_fault[i]});
                chk($sformatf("fault_addr%0d", i), fault_addr[i], m_fa[i]);
            end
            if (reset && if_ready) begin
                if (if_valid[0] && !(redirect_valid && !fault[0])) del0.push_back(if_pc[0]);
                if (if_valid[1] && !(redirect_valid && !fault[1])) del1.push_back(if_pc[1]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        en = 1'b1;
        chk("rst_if_valid", {31'd0, if_valid[0]}, 32'd0);
        chk("rst_imem_addr", imem_addr[0], 32'h0);
        chk("rst_fault", {31'd0, fault[0]}, 32'd0);
        chk("rst_fault_addr", fault_addr[0], 32'h0);

        // Basic streaming from RESET_PC.
        if_ready = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("c1_if_pc", if_pc[0], 32'h0);
        chk("c1_if_instr", if_instr[0], 32'h0000_0013);
        chk("c1_imem_addr", imem_addr[0], 32'h4);
        tick(1);
        chk("c2_if_pc", if_pc[0], 32'h4);
        chk("c2_if_instr", if_instr[0], 32'h0010_0093);
        chk("c2_imem_addr", imem_addr[0], 32'h8);

        // Stall with decode not ready, then drain in order.
        reset = 1'b0;
        if_ready = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(5);
        chk("stall_imem_addr", imem_addr[0], 32'h8);
        chk("stall_if_pc", if_pc[0], 32'h0);
        chk("stall_if_valid", {31'd0, if_valid[0]}, 32'd1);
        del0.delete();
        del1.delete();
        if_ready = 1'b1;
        tick(8);
        chk("drain_n", del0.size(), 32'd8);
        chk("drain_0", (del0.size() > 0) ? del0[0] : 32'hFFFF_FFFF, 32'h0);
        chk("drain_1", (del0.size() > 1) ? del0[1] : 32'hFFFF_FFFF, 32'h4);
        chk("drain_2", (del0.size() > 2) ? del0[2] : 32'hFFFF_FFFF, 32'h8);
        chk("ovr_fault", {31'd0, fault[1]}, 32'd1);
        chk("ovr_fault_addr", fault_addr[1], 32'h10);
        chk("ovr_count", del1.size(), 32'd4);
        chk("ovr_last", (del1.size() > 0) ? del1[del1.size()-1] : 32'hFFFF_FFFF, 32'hC);

        // Redirect with a full queue and a same-cycle pop.
        del0.delete();
        chk("pre_redir_full_valid", {31'd0, if_valid[0]}, 32'd1);
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        chk("redir_flush_valid", {31'd0, if_valid[0]}, 32'd0);
        tick(1);
        chk("redir_if_pc", if_pc[0], 32'h100);
        chk("redir_if_valid", {31'd0, if_valid[0]}, 32'd1);
        tick(3);
        foreach (del0[k]) chk("redir_no_stale", {31'd0, del0[k] >= 32'h100}, 32'd1);

        // Misaligned redirect faults; later redirects are ignored.
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        tick(1);
        redirect_valid = 1'b0;
        chk("mis_fault", {31'd0, fault[0]}, 32'd1);
        chk("mis_fault_addr", fault_addr[0], 32'h102);
        chk("mis_if_valid", {31'd0, if_valid[0]}, 32'd0);
        tick(2);
        redirect_valid = 1'b1;
        redirect_target = 32'h0;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        chk("ign_fault", {31'd0, fault[0]}, 32'd1);
        chk("ign_fault_addr", fault_addr[0], 32'h102);
        chk("ign_if_valid", {31'd0, if_valid[0]}, 32'd0);

        // Asynchronous reset with a full queue.
        reset = 1'b0;
        if_ready = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(4);
        chk("full_before_rst", {31'd0, if_valid[0]}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_if_valid", {31'd0, if_valid[0]}, 32'd0);
        chk("async_fault", {31'd0, fault[0]}, 32'd0);
        chk("async_imem_addr", imem_addr[0], 32'h0);
        chk("async_if_pc", if_pc[0], 32'h0);
        tick(1);
        reset = 1'b1;
        if_ready = 1'b1;
        tick(1);
        chk("restart_if_pc", if_pc[0], 32'h0);
        chk("restart_if_instr", if_instr[0], 32'h0000_0013);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
